// File: rtl/nec_ir_command_controller.sv
// NEC IR frame validator/debouncer mapping button codes onto LED brightness, mode and enable registers.
// Optional feature: define NEC_CMD_AUTOREPEAT_EN to apply repeated UP/DOWN inside holdoff at double step.
`timescale 1ns/1ps
module nec_ir_command_controller #(
    parameter logic [7:0] DEVICE_ADDR     = 8'h00,
    parameter int         HOLDOFF_CYCLES  = 10_000_000,
    parameter logic [7:0] BRIGHTNESS_INIT = 8'd128,
    parameter logic [7:0] BRIGHTNESS_STEP = 8'd16,
    parameter int         MODE_COUNT      = 8,
    parameter logic [7:0] CMD_UP          = 8'h18,
    parameter logic [7:0] CMD_DOWN        = 8'h52,
    parameter logic [7:0] CMD_NEXT        = 8'h5A,
    parameter logic [7:0] CMD_PREV        = 8'h08,
    parameter logic [7:0] CMD_POWER       = 8'h45
) (
    input  logic        clkIN,
    input  logic        resetIN,
    input  logic        rxReadyIN,
    input  logic [31:0] dataIN,
    output logic [7:0]  commandOUT,
    output logic        cmdValidOUT,
    output logic        frameErrorOUT,
    output logic [7:0]  brightnessOUT,
    output logic [2:0]  modeOUT,
    output logic        enableOUT
);
    localparam int            CW        = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLDOFF_CYCLES - 1);
    localparam logic [2:0]    MODE_MAX  = 3'(MODE_COUNT - 1);

    typedef enum logic [1:0] {IDLE, CHECK, APPLY, HOLDOFF} state_t;

    state_t        state, state_next, ret_state;
    logic          rx_prev;
    logic [31:0]   frame_reg;
    logic [7:0]    last_cmd;
    logic [CW-1:0] hold_cnt;
    logic [7:0]    f_addr, f_addr_inv, f_cmd, f_cmd_inv;
    logic          rx_edge, in_holdoff, complement_ok, is_repeat, repeat_allowed;
    logic          err_pulse, latch_frame;
    logic [9:0]    step, b_up;
    logic [7:0]    b_up_sat, b_down_sat;

    assign f_addr     = frame_reg[31:24];
    assign f_addr_inv = frame_reg[23:16];
    assign f_cmd      = frame_reg[15:8];
    assign f_cmd_inv  = frame_reg[7:0];

`ifdef NEC_CMD_AUTOREPEAT_EN
    // Remembers that the frame being applied is a held UP/DOWN key.
    logic repeat_reg;
    always_ff @(posedge clkIN) begin
        if (resetIN)
            repeat_reg <= 1'b0;
        else if (state == CHECK)
            repeat_reg <= is_repeat;
    end
    assign repeat_allowed = (f_cmd == CMD_UP) || (f_cmd == CMD_DOWN);
    assign step = repeat_reg ? {1'b0, BRIGHTNESS_STEP, 1'b0} : {2'b00, BRIGHTNESS_STEP};
`else
    assign repeat_allowed = 1'b0;
    assign step = {2'b00, BRIGHTNESS_STEP};
`endif

    assign b_up       = {2'b00, brightnessOUT} + step;
    assign b_up_sat   = (b_up > 10'd255) ? 8'hFF : b_up[7:0];
    assign b_down_sat = ({2'b00, brightnessOUT} < step) ? 8'h00
                        : 8'({2'b00, brightnessOUT} - step);

    always_comb begin
        state_next    = state;
        err_pulse     = 1'b0;
        latch_frame   = 1'b0;
        rx_edge       = rxReadyIN && !rx_prev;
        in_holdoff    = (hold_cnt != '0);
        ret_state     = in_holdoff ? HOLDOFF : IDLE;
        complement_ok = (f_addr == ~f_addr_inv) && (f_cmd == ~f_cmd_inv);
        is_repeat     = in_holdoff && (f_cmd == last_cmd);
        case (state)
            IDLE: begin
                if (rx_edge) begin
                    state_next  = CHECK;
                    latch_frame = 1'b1;
                end
            end
            CHECK: begin
                if (!complement_ok) begin
                    err_pulse  = 1'b1;
                    state_next = ret_state;
                end else if (f_addr != DEVICE_ADDR) begin
                    state_next = ret_state;
                end else if (is_repeat && !repeat_allowed) begin
                    state_next = ret_state;
                end else begin
                    state_next = APPLY;
                end
            end
            APPLY: state_next = HOLDOFF;
            HOLDOFF: begin
                if (rx_edge) begin
                    state_next  = CHECK;
                    latch_frame = 1'b1;
                end else if (!in_holdoff) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clkIN) begin
        if (resetIN) begin
            state         <= IDLE;
            rx_prev       <= 1'b1;
            frame_reg     <= '0;
            last_cmd      <= '0;
            hold_cnt      <= '0;
            commandOUT    <= '0;
            cmdValidOUT   <= 1'b0;
            frameErrorOUT <= 1'b0;
            brightnessOUT <= BRIGHTNESS_INIT;
            modeOUT       <= '0;
            enableOUT     <= 1'b1;
        end else begin
            state         <= state_next;
            rx_prev       <= rxReadyIN;
            cmdValidOUT   <= 1'b0;
            frameErrorOUT <= err_pulse;
            if (latch_frame)
                frame_reg <= dataIN;
            // The counter keeps running through CHECK so a rejected frame resumes the same holdoff.
            if (state == APPLY) begin
                hold_cnt    <= HOLD_LOAD;
                commandOUT  <= f_cmd;
                cmdValidOUT <= 1'b1;
                last_cmd    <= f_cmd;
                if (f_cmd == CMD_UP)
                    brightnessOUT <= b_up_sat;
                else if (f_cmd == CMD_DOWN)
                    brightnessOUT <= b_down_sat;
                else if (f_cmd == CMD_NEXT)
                    modeOUT <= (modeOUT == MODE_MAX) ? 3'd0 : modeOUT + 3'd1;
                else if (f_cmd == CMD_PREV)
                    modeOUT <= (modeOUT == 3'd0) ? MODE_MAX : modeOUT - 3'd1;
                else if (f_cmd == CMD_POWER)
                    enableOUT <= ~enableOUT;
            end else if (in_holdoff) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
        end
    end
endmodule
